// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of one synchronous memory port between
// the CPU instruction-fetch port and the data load/store port.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_read,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_readdata,
  output logic                i_wait,
  input  logic                d_read,
  input  logic                d_write,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_writedata,
  input  logic [DATA_W/8-1:0] d_byteenable,
  output logic [DATA_W-1:0]   d_readdata,
  output logic                d_wait,
  output logic                m_read,
  output logic                m_write,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_writedata,
  output logic [DATA_W/8-1:0] m_byteenable,
  input  logic [DATA_W-1:0]   m_readdata,
  input  logic                m_waitrequest
);

  localparam int unsigned BE_W = DATA_W / 8;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE_I, S_ISSUE_D, S_DATA_I, S_DATA_D
  } state_t;

  state_t            state_q, state_d;
  logic              last_d_q, last_d_d;     // 1: most recent grant went to data port
  logic              m_read_q, m_read_d;
  logic              m_write_q, m_write_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic [BE_W-1:0]   m_be_q, m_be_d;

  logic d_req, grant_i, i_done, d_rd_done, d_wr_done;

  // Request decode and completion detection; completions are only signalled
  // while the requester still holds its request.
  always_comb begin
    d_req     = d_read | d_write;
    grant_i   = i_read & (~d_req | last_d_q);
    i_done    = (state_q == S_DATA_I) & i_read;
    d_rd_done = (state_q == S_DATA_D) & d_read;
    d_wr_done = (state_q == S_ISSUE_D) & m_write_q & ~m_waitrequest & d_write;
  end

  assign i_wait       = i_read & ~i_done;
  assign d_wait       = d_req & ~(d_rd_done | d_wr_done);
  assign i_readdata   = i_done ? m_readdata : '0;
  assign d_readdata   = d_rd_done ? m_readdata : '0;
  assign m_read       = m_read_q;
  assign m_write      = m_write_q;
  assign m_addr       = m_addr_q;
  assign m_writedata  = m_wdata_q;
  assign m_byteenable = m_be_q;

  // Next-state and next memory-command computation.
  always_comb begin
    state_d   = state_q;
    last_d_d  = last_d_q;
    m_read_d  = m_read_q;
    m_write_d = m_write_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    m_be_d    = m_be_q;
    case (state_q)
      S_IDLE: begin
        if (grant_i) begin
          state_d   = S_ISSUE_I;
          last_d_d  = 1'b0;
          m_read_d  = 1'b1;
          m_write_d = 1'b0;
          m_addr_d  = i_addr;
          m_be_d    = '1;
        end else if (d_req) begin
          state_d   = S_ISSUE_D;
          last_d_d  = 1'b1;
          m_read_d  = ~d_write;
          m_write_d = d_write;
          m_addr_d  = d_addr;
          m_wdata_d = d_writedata;
          m_be_d    = d_byteenable;
        end
      end
      S_ISSUE_I: begin
        if (!m_waitrequest) begin
          state_d  = S_DATA_I;
          m_read_d = 1'b0;
        end
      end
      S_ISSUE_D: begin
        if (!m_waitrequest) begin
          state_d   = m_write_q ? S_IDLE : S_DATA_D;
          m_read_d  = 1'b0;
          m_write_d = 1'b0;
        end
      end
      S_DATA_I, S_DATA_D: state_d = S_IDLE;
      default: begin
        state_d   = S_IDLE;
        m_read_d  = 1'b0;
        m_write_d = 1'b0;
      end
    endcase
  end

  // State and memory-command registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      last_d_q  <= 1'b1;
      m_read_q  <= 1'b0;
      m_write_q <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_be_q    <= '0;
    end else begin
      state_q   <= state_d;
      last_d_q  <= last_d_d;
      m_read_q  <= m_read_d;
      m_write_q <= m_write_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_be_q    <= m_be_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: synchronous RAM model, directed scenarios, then
// randomized concurrent fetch/load/store traffic checked by a scoreboard.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_read, d_read, d_write;
  logic [31:0] i_addr, d_addr, d_writedata;
  logic [3:0]  d_byteenable;
  logic [31:0] i_readdata, d_readdata;
  logic        i_wait, d_wait;
  logic        m_read, m_write;
  logic [31:0] m_addr, m_writedata, m_readdata;
  logic [3:0]  m_byteenable;
  logic        m_waitrequest;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .i_read(i_read), .i_addr(i_addr), .i_readdata(i_readdata), .i_wait(i_wait),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_writedata(d_writedata),
    .d_byteenable(d_byteenable), .d_readdata(d_readdata), .d_wait(d_wait),
    .m_read(m_read), .m_write(m_write), .m_addr(m_addr), .m_writedata(m_writedata),
    .m_byteenable(m_byteenable), .m_readdata(m_readdata), .m_waitrequest(m_waitrequest)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // memory model storage (imem: addr[31]=1 region, dmem: low region)
  logic [31:0] imem [64];
  logic [31:0] dmem [64];
  // reference model copies, updated when a transaction is issued
  logic [31:0] rimem [64];
  logic [31:0] rdmem [64];

  logic [31:0] iq[$];
  logic [31:0] dq[$];
  logic        log_en = 1'b0;
  bit          comp_side[$];
  int          comp_cyc[$];

  logic force_wr = 1'b0;
  logic rand_en  = 1'b0;
  logic rnd_wr   = 1'b0;
  assign m_waitrequest = force_wr | rnd_wr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous RAM: data one cycle after an accepted read, lane-masked writes.
  always @(posedge clk) begin
    rnd_wr <= rand_en && ($urandom_range(0, 3) == 0);
    if (m_read && !m_waitrequest)
      m_readdata <= m_addr[31] ? imem[m_addr[7:2]] : dmem[m_addr[7:2]];
    else
      m_readdata <= 32'h0;
    if (m_write && !m_waitrequest && !m_addr[31])
      for (int b = 0; b < 4; b++)
        if (m_byteenable[b]) dmem[m_addr[7:2]][b*8 +: 8] <= m_writedata[b*8 +: 8];
  end

  // Monitor: pops the scoreboard on each completion and checks command stability.
  logic        p_stall = 1'b0;
  logic [68:0] p_cmd;
  always @(negedge clk) begin
    if (p_stall)
      check("stall_hold", 32'({m_read, m_write, m_addr} ^ p_cmd[33:0]), 32'({p_cmd[68:35]} ^ p_cmd[33:0]));
    p_stall <= (m_read | m_write) & m_waitrequest & ~reset;
    p_cmd   <= {m_read, m_write, m_addr, 1'b0, m_read, m_write, m_addr};
    if (d_read && d_write) begin
      bad++;
      $display("FAIL bench_illegal_rw: d_read=%b d_write=%b", d_read, d_write);
    end
    if (!reset && i_read && !i_wait) begin
      if (iq.size() == 0) check("i_unexpected", 32'd1, 32'd0);
      else check("i_readdata", i_readdata, iq.pop_front());
      check("d_rd_idle_zero", d_readdata, 32'h0);
      if (log_en) begin comp_side.push_back(1'b0); comp_cyc.push_back(cyc); end
    end
    if (!reset && d_read && !d_wait) begin
      if (dq.size() == 0) check("d_unexpected", 32'd1, 32'd0);
      else check("d_readdata", d_readdata, dq.pop_front());
      check("i_rd_idle_zero", i_readdata, 32'h0);
      if (log_en) begin comp_side.push_back(1'b1); comp_cyc.push_back(cyc); end
    end
  end

  task automatic wait_done_i(output int lat);
    lat = 0;
    forever begin
      @(negedge clk); lat++;
      if (!i_wait) break;
      if (lat > 60) begin check("i_timeout", 32'(lat), 32'd0); break; end
    end
    @(posedge clk); #1 i_read = 1'b0;
  endtask

  task automatic wait_done_d(output int lat);
    lat = 0;
    forever begin
      @(negedge clk); lat++;
      if (!d_wait) break;
      if (lat > 60) begin check("d_timeout", 32'(lat), 32'd0); break; end
    end
    @(posedge clk); #1 begin d_read = 1'b0; d_write = 1'b0; end
  endtask

  task automatic do_fetch(input int k, output int lat);
    i_addr = 32'hBFC0_0000 + 32'(k * 4);
    i_read = 1'b1;
    iq.push_back(rimem[k]);
    wait_done_i(lat);
  endtask

  task automatic do_load(input int k, output int lat);
    d_addr = 32'h0000_1000 + 32'(k * 4);
    d_byteenable = 4'hF;
    d_read = 1'b1;
    dq.push_back(rdmem[k]);
    wait_done_d(lat);
  endtask

  task automatic do_store(input int k, input logic [31:0] wd, input logic [3:0] be, output int lat);
    d_addr = 32'h0000_1000 + 32'(k * 4);
    d_writedata = wd;
    d_byteenable = be;
    d_write = 1'b1;
    for (int b = 0; b < 4; b++)
      if (be[b]) rdmem[k][b*8 +: 8] = wd[b*8 +: 8];
    wait_done_d(lat);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1 reset = 1'b1;
    repeat (n) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  int lat_a, lat_b;
  logic [31:0] hold_addr;

  initial begin
    reset = 1'b1; i_read = 0; d_read = 0; d_write = 0;
    i_addr = 0; d_addr = 0; d_writedata = 0; d_byteenable = 0;
    for (int k = 0; k < 64; k++) begin
      imem[k] = $urandom; dmem[k] = $urandom;
    end
    imem[0] = 32'h2402_0005;
    for (int k = 0; k < 64; k++) begin rimem[k] = imem[k]; rdmem[k] = dmem[k]; end

    // 1: reset, idle
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_m_read", 32'(m_read), 32'd0);
    check("rst_m_write", 32'(m_write), 32'd0);
    check("rst_i_wait", 32'(i_wait), 32'd0);
    check("rst_d_wait", 32'(d_wait), 32'd0);
    check("rst_m_addr", m_addr, 32'h0);

    // 2: single unloaded fetch
    @(posedge clk); #1 i_addr = 32'hBFC0_0000; i_read = 1'b1; iq.push_back(32'h2402_0005);
    @(posedge clk); #1;
    check("f_m_read", 32'(m_read), 32'd1);
    check("f_m_addr", m_addr, 32'hBFC0_0000);
    check("f_m_be", 32'(m_byteenable), 32'hF);
    check("f_wait_c1", 32'(i_wait), 32'd1);
    @(posedge clk); #1;
    check("f_wait_c2", 32'(i_wait), 32'd0);
    check("f_rdata_c2", i_readdata, 32'h2402_0005);
    @(posedge clk); #1 i_read = 1'b0;

    // 3: contention after reset, fetch wins, then store
    do_reset(1);
    @(posedge clk); #1;
    fork
      do_fetch(4, lat_a);
      do_store(0, 32'hDEAD_BEEF, 4'b0011, lat_b);
      begin
        @(posedge clk); #2;
        check("c_first_read", 32'({m_read, m_write}), 32'b10);
        check("c_first_addr", m_addr, 32'hBFC0_0010);
        repeat (3) @(posedge clk); #2;
        check("c_store_wr", 32'({m_read, m_write}), 32'b01);
        check("c_store_addr", m_addr, 32'h0000_1000);
        check("c_store_be", 32'(m_byteenable), 32'b0011);
        check("c_store_wdata", m_writedata, 32'hDEAD_BEEF);
      end
    join
    check("c_fetch_lat", 32'(lat_a), 32'd3);
    check("c_store_lat", 32'(lat_b), 32'd5);
    do_load(0, lat_a);
    check("load_lat", 32'(lat_a), 32'd3);

    // 4: sustained contention alternates I,D every 3 cycles
    do_reset(1);
    comp_side.delete(); comp_cyc.delete();
    @(posedge clk); #1 log_en = 1'b1;
    fork
      repeat (3) do_fetch($urandom_range(0, 63), lat_a);
      repeat (3) do_load($urandom_range(0, 63), lat_b);
    join
    log_en = 1'b0;
    check("rr_count", 32'(comp_side.size()), 32'd6);
    for (int k = 0; k < comp_side.size(); k++) begin
      check("rr_order", 32'(comp_side[k]), 32'(k % 2));
      if (k > 0) check("rr_spacing", 32'(comp_cyc[k] - comp_cyc[k-1]), 32'd3);
    end

    // 5: three stall cycles during a load
    @(posedge clk); #1 d_addr = 32'h0000_1000 + 32'd40; d_byteenable = 4'hF; d_read = 1'b1;
    dq.push_back(rdmem[10]); force_wr = 1'b1;
    @(posedge clk); #1;
    check("st_m_read", 32'(m_read), 32'd1);
    hold_addr = m_addr;
    check("st_addr", hold_addr, 32'h0000_1028);
    repeat (2) begin
      @(posedge clk); #1;
      check("st_hold_addr", m_addr, hold_addr);
      check("st_hold_read", 32'(m_read), 32'd1);
    end
    @(posedge clk); #1 force_wr = 1'b0;
    check("st_accept_read", 32'(m_read), 32'd1);
    @(negedge clk); check("st_wait_c4", 32'(d_wait), 32'd1);
    @(negedge clk); check("st_wait_c5", 32'(d_wait), 32'd0);
    @(posedge clk); #1 d_read = 1'b0;

    // request dropped mid-transaction: no completion data
    @(posedge clk); #1 i_addr = 32'hBFC0_0008; i_read = 1'b1;
    @(posedge clk); #1 i_read = 1'b0;
    check("drop_issue", 32'(m_read), 32'd1);
    @(posedge clk); #1 check("drop_rdata", i_readdata, 32'h0);
    repeat (2) @(posedge clk);

    // 6: reset during a stalled store
    #1 d_addr = 32'h0000_1004; d_writedata = 32'h1234_5678; d_byteenable = 4'hF;
    d_write = 1'b1; force_wr = 1'b1;
    @(posedge clk); #1;
    check("rs_m_write", 32'(m_write), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rs_m_write_clr", 32'(m_write), 32'd0);
    reset = 1'b0; force_wr = 1'b0; d_write = 1'b0;
    do_store(2, 32'hCAFE_F00D, 4'b1100, lat_a);
    check("rs_store_lat", 32'(lat_a), 32'd2);
    do_load(1, lat_a);
    do_load(2, lat_a);

    // random concurrent traffic with random memory stalls
    rand_en = 1'b1;
    fork
      repeat (80) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1 do_fetch($urandom_range(0, 63), lat_a);
      end
      repeat (80) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
        if ($urandom_range(0, 1) == 1)
          do_store($urandom_range(0, 15), $urandom, 4'($urandom_range(1, 15)), lat_b);
        else
          do_load($urandom_range(0, 15), lat_b);
      end
    join
    rand_en = 1'b0;
    repeat (4) @(posedge clk);
    check("iq_drained", 32'(iq.size()), 32'd0);
    check("dq_drained", 32'(dq.size()), 32'd0);
    for (int k = 0; k < 16; k++) check("final_dmem", dmem[k], rdmem[k]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: cycle %0d", cyc);
    $fatal(1);
  end

endmodule
